// File: rtl/contador_pkg.sv
// Shared encodings for the contador_xy up/down counter: FSM states and {x,y} command codes.
package contador_pkg;

    typedef enum logic [1:0] {
        REPOSO = 2'b00,
        SUBE   = 2'b01,
        BAJA   = 2'b10,
        PAUSA  = 2'b11
    } estado_e;

    localparam logic [1:0] CMD_HOLD = 2'b00;
    localparam logic [1:0] CMD_DOWN = 2'b01;
    localparam logic [1:0] CMD_UP   = 2'b10;
    localparam logic [1:0] CMD_LOAD = 2'b11;

endpackage

// File: rtl/sumador_limite.sv
// Combinational +1/-1 step with limit detection; wraps or saturates depending on WRAP.
module sumador_limite #(
    parameter int unsigned WIDTH = 3,
    parameter bit          WRAP  = 1'b1
) (
    input  logic [WIDTH-1:0] z,
    input  logic             subir,
    output logic [WIDTH-1:0] z_sig,
    output logic             limite
);

    localparam logic [WIDTH:0] UNO = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH:0] ext;

    always_comb begin
        ext = subir ? ({1'b0, z} + UNO) : ({1'b0, z} - UNO);
        // The extra bit is the carry on the way up and the borrow on the way down.
        limite = ext[WIDTH];
        if (WRAP) begin
            z_sig = ext[WIDTH-1:0];
        end else begin
            z_sig = limite ? z : ext[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/contador_xy.sv
// 3-bit up/down counter with parallel load driven by the {x,y} command pair; a direction
// reversal costs one PAUSA cycle. Z and I are registered.
module contador_xy
    import contador_pkg::*;
#(
    parameter int unsigned WIDTH = 3,
    parameter bit          WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             r,
    input  logic             x,
    input  logic             y,
    input  logic [WIDTH-1:0] L,
    output logic [WIDTH-1:0] Z,
    output logic             I
);

    estado_e          estado_q, estado_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic             i_q, i_d;
    logic [1:0]       cmd;
    logic [WIDTH-1:0] z_sig;
    logic             limite;

    assign cmd = {x, y};

    sumador_limite #(
        .WIDTH(WIDTH),
        .WRAP (WRAP)
    ) u_sumador (
        .z     (z_q),
        .subir (cmd == CMD_UP),
        .z_sig (z_sig),
        .limite(limite)
    );

    always_comb begin
        estado_d = REPOSO;
        z_d      = z_q;
        i_d      = 1'b0;
        unique case (cmd)
            CMD_HOLD: begin
                estado_d = REPOSO;
            end
            CMD_LOAD: begin
                z_d      = L;
                estado_d = REPOSO;
            end
            CMD_UP: begin
                if (estado_q == BAJA) begin
                    estado_d = PAUSA;
                end else begin
                    z_d      = z_sig;
                    i_d      = limite;
                    estado_d = SUBE;
                end
            end
            CMD_DOWN: begin
                if (estado_q == SUBE) begin
                    estado_d = PAUSA;
                end else begin
                    z_d      = z_sig;
                    i_d      = limite;
                    estado_d = BAJA;
                end
            end
            default: begin
                estado_d = REPOSO;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (r) begin
            estado_q <= REPOSO;
            z_q      <= '0;
            i_q      <= 1'b0;
        end else begin
            estado_q <= estado_d;
            z_q      <= z_d;
            i_q      <= i_d;
        end
    end

    assign Z = z_q;
    assign I = i_q;

endmodule

// File: tb/tb_contador_xy.sv
// Drives a wrapping and a saturating contador_xy with the same stimulus and checks both.
module tb_contador_xy;

    typedef struct packed {
        logic       r;
        logic [1:0] cmd;
        logic [2:0] l;
        logic [2:0] zw;
        logic       iw;
        logic [2:0] zs;
        logic       is;
    } vec_t;

    logic       clk = 1'b0;
    logic       r   = 1'b1;
    logic       x   = 1'b1;
    logic       y   = 1'b1;
    logic [2:0] l   = 3'b101;
    logic [2:0] z_w, z_s;
    logic       i_w, i_s;

    int   total = 0;
    int   bad   = 0;
    vec_t exp_q[$];
    vec_t tbl[25];

    always #5 clk = ~clk;

    contador_xy #(.WIDTH(3), .WRAP(1'b1)) u_wrap (
        .clk(clk), .r(r), .x(x), .y(y), .L(l), .Z(z_w), .I(i_w)
    );

    contador_xy #(.WIDTH(3), .WRAP(1'b0)) u_sat (
        .clk(clk), .r(r), .x(x), .y(y), .L(l), .Z(z_s), .I(i_s)
    );

    function automatic vec_t mk(logic rr, logic [1:0] c, logic [2:0] ll,
                                logic [2:0] zw, logic iw, logic [2:0] zs, logic is);
        vec_t v;
        v.r = rr; v.cmd = c; v.l = ll; v.zw = zw; v.iw = iw; v.zs = zs; v.is = is;
        return v;
    endfunction

    task automatic check(string name, int idx, logic [2:0] got, logic [2:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s step %0d: got %b, required %b", name, idx, got, want);
        end
    endtask

    task automatic step(vec_t v, int idx);
        vec_t e;
        @(negedge clk);
        r = v.r;
        {x, y} = v.cmd;
        l = v.l;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("z_wrap", idx, z_w, e.zw);
        check("i_wrap", idx, {2'b00, i_w}, {2'b00, e.iw});
        check("z_sat", idx, z_s, e.zs);
        check("i_sat", idx, {2'b00, i_s}, {2'b00, e.is});
    endtask

    initial begin
        //            r     cmd    L       Zwrap   Iw    Zsat    Is
        tbl[0]  = mk(1'b1, 2'b11, 3'b101, 3'b000, 1'b0, 3'b000, 1'b0);
        tbl[1]  = mk(1'b1, 2'b11, 3'b101, 3'b000, 1'b0, 3'b000, 1'b0);
        tbl[2]  = mk(1'b0, 2'b11, 3'b110, 3'b110, 1'b0, 3'b110, 1'b0);
        tbl[3]  = mk(1'b0, 2'b00, 3'b000, 3'b110, 1'b0, 3'b110, 1'b0);
        tbl[4]  = mk(1'b0, 2'b00, 3'b000, 3'b110, 1'b0, 3'b110, 1'b0);
        tbl[5]  = mk(1'b0, 2'b11, 3'b110, 3'b110, 1'b0, 3'b110, 1'b0);
        tbl[6]  = mk(1'b0, 2'b10, 3'b000, 3'b111, 1'b0, 3'b111, 1'b0);
        tbl[7]  = mk(1'b0, 2'b10, 3'b000, 3'b000, 1'b1, 3'b111, 1'b1);
        tbl[8]  = mk(1'b0, 2'b10, 3'b000, 3'b001, 1'b0, 3'b111, 1'b1);
        tbl[9]  = mk(1'b0, 2'b11, 3'b010, 3'b010, 1'b0, 3'b010, 1'b0);
        tbl[10] = mk(1'b0, 2'b10, 3'b000, 3'b011, 1'b0, 3'b011, 1'b0);
        tbl[11] = mk(1'b0, 2'b01, 3'b000, 3'b011, 1'b0, 3'b011, 1'b0);
        tbl[12] = mk(1'b0, 2'b01, 3'b000, 3'b010, 1'b0, 3'b010, 1'b0);
        tbl[13] = mk(1'b0, 2'b11, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0);
        tbl[14] = mk(1'b0, 2'b01, 3'b000, 3'b111, 1'b1, 3'b000, 1'b1);
        tbl[15] = mk(1'b0, 2'b01, 3'b000, 3'b110, 1'b0, 3'b000, 1'b1);
        tbl[16] = mk(1'b0, 2'b10, 3'b000, 3'b110, 1'b0, 3'b000, 1'b0);
        tbl[17] = mk(1'b0, 2'b10, 3'b000, 3'b111, 1'b0, 3'b001, 1'b0);
        tbl[18] = mk(1'b0, 2'b11, 3'b100, 3'b100, 1'b0, 3'b100, 1'b0);
        tbl[19] = mk(1'b0, 2'b10, 3'b000, 3'b101, 1'b0, 3'b101, 1'b0);
        tbl[20] = mk(1'b1, 2'b10, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0);
        tbl[21] = mk(1'b0, 2'b01, 3'b000, 3'b111, 1'b1, 3'b000, 1'b1);
        tbl[22] = mk(1'b0, 2'b10, 3'b000, 3'b111, 1'b0, 3'b000, 1'b0);
        tbl[23] = mk(1'b0, 2'b11, 3'b011, 3'b011, 1'b0, 3'b011, 1'b0);
        tbl[24] = mk(1'b0, 2'b01, 3'b000, 3'b010, 1'b0, 3'b010, 1'b0);

        for (int i = 0; i < 25; i++) begin
            step(tbl[i], i);
        end

        // Top limit, then hold clears I, then a down from REPOSO and an up-reversal pause.
        step(mk(1'b0, 2'b11, 3'b111, 3'b111, 1'b0, 3'b111, 1'b0), 100);
        step(mk(1'b0, 2'b10, 3'b000, 3'b000, 1'b1, 3'b111, 1'b1), 101);
        step(mk(1'b0, 2'b00, 3'b000, 3'b000, 1'b0, 3'b111, 1'b0), 102);
        step(mk(1'b0, 2'b01, 3'b000, 3'b111, 1'b1, 3'b110, 1'b0), 103);
        step(mk(1'b0, 2'b10, 3'b000, 3'b111, 1'b0, 3'b110, 1'b0), 104);
        step(mk(1'b0, 2'b10, 3'b000, 3'b000, 1'b1, 3'b111, 1'b0), 105);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
